// File: rtl/ram_responder_if.sv
// Byte-serial RAM port plus console TX/RX handshakes.
// The master drives requests; the slave is the memory-side responder.
interface ram_responder_if;
  logic        in_ram_rw;
  logic [31:0] in_ram_address;
  logic [7:0]  in_ram_data;
  logic [7:0]  out_ram_data;
  logic        out_tx_valid;
  logic [7:0]  out_tx_data;
  logic        in_tx_ready;
  logic        in_rx_valid;
  logic [7:0]  in_rx_data;
  logic        out_rx_ready;
  logic        out_halt;

  modport master (
    output in_ram_rw, in_ram_address, in_ram_data,
    output in_tx_ready, in_rx_valid, in_rx_data,
    input  out_ram_data, out_tx_valid, out_tx_data,
    input  out_rx_ready, out_halt
  );

  modport slave (
    input  in_ram_rw, in_ram_address, in_ram_data,
    input  in_tx_ready, in_rx_valid, in_rx_data,
    output out_ram_data, out_tx_valid, out_tx_data,
    output out_rx_ready, out_halt
  );
endinterface

// File: rtl/ram_responder.sv
// Memory-side responder: byte RAM, I/O window at 0x30000,
// console TX/RX FIFOs, sticky halt and overflow flags.
module ram_responder #(
  parameter int ADDR_BITS      = 17,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  ram_responder_if.slave bus
);
  localparam int FL = FIFO_DEPTH_LOG;
  localparam logic [FL:0] FULL = {1'b1, {FL{1'b0}}};

  logic [7:0] mem_q [2**ADDR_BITS];
  logic [7:0] tx_mem_q [2**FL];
  logic [7:0] rx_mem_q [2**FL];

  logic [FL-1:0] tx_rd_q, tx_wr_q;
  logic [FL-1:0] rx_rd_q, rx_wr_q;
  logic [FL:0]   tx_cnt_q, rx_cnt_q;
  logic          ovf_q, halt_q;
  logic [7:0]    rdata_q, rdata_d;

  logic [ADDR_BITS-1:0] idx;
  logic io_sel, io_a0, io_a4;
  logic wr, rd;
  logic tx_full, tx_pop, tx_req, tx_push, ovf_set;
  logic rx_nempty, rx_pop, rx_push;
  logic [7:0] status;
  logic unused_addr;

  assign idx    = bus.in_ram_address[ADDR_BITS-1:0];
  assign io_sel = bus.in_ram_address[17:16] == 2'b11;
  assign io_a0  = io_sel & (bus.in_ram_address[15:0] == 16'h0000);
  assign io_a4  = io_sel & (bus.in_ram_address[15:0] == 16'h0004);
  assign unused_addr = ^bus.in_ram_address;

  assign wr = rdy & bus.in_ram_rw;
  assign rd = rdy & ~bus.in_ram_rw;

  // A full TX FIFO still takes a byte when the head leaves this cycle
  assign tx_full = tx_cnt_q == FULL;
  assign tx_pop  = (tx_cnt_q != '0) & bus.in_tx_ready;
  assign tx_req  = wr & io_a0;
  assign tx_push = tx_req & (~tx_full | tx_pop);
  assign ovf_set = tx_req & tx_full & ~tx_pop;

  assign rx_nempty = rx_cnt_q != '0;
  assign rx_pop    = rd & io_a0 & rx_nempty;
  assign rx_push   = bus.in_rx_valid & (rx_cnt_q != FULL);

  assign status = {5'b0, ovf_q, rx_nempty, tx_full};

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      unique case (1'b1)
        ~io_sel: rdata_d = mem_q[idx];
        io_a0:   rdata_d = rx_nempty ? rx_mem_q[rx_rd_q] : 8'h00;
        io_a4:   rdata_d = status;
        default: rdata_d = 8'h00;
      endcase
    end
  end

  // Storage arrays carry no reset
  always_ff @(posedge clk) begin
    if (wr & ~io_sel) mem_q[idx] <= bus.in_ram_data;
    if (tx_push) tx_mem_q[tx_wr_q] <= bus.in_ram_data;
    if (rx_push) rx_mem_q[rx_wr_q] <= bus.in_rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q  <= '0;
      halt_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_cnt_q <= '0;
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (ovf_set) ovf_q <= 1'b1;
      if (wr & io_a4) halt_q <= 1'b1;
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  assign bus.out_ram_data = rdata_q;
  assign bus.out_tx_valid = tx_cnt_q != '0;
  assign bus.out_tx_data  = tx_mem_q[tx_rd_q];
  assign bus.out_rx_ready = rx_cnt_q != FULL;
  assign bus.out_halt     = halt_q;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: memory, aliasing,
// TX/RX FIFOs, overflow, halt, rdy freeze and reset.
module tb_ram_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  int n_chk = 0;
  int n_pass = 0;

  ram_responder_if bus();

  ram_responder dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic req(input logic r, input logic w,
                     input logic [31:0] a,
                     input logic [7:0] d);
    rdy = r;
    bus.in_ram_rw = w;
    bus.in_ram_address = a;
    bus.in_ram_data = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req(1'b1, 1'b0, 32'h10, 8'h00);
    bus.in_tx_ready = 1'b0;
    bus.in_rx_valid = 1'b0;
    bus.in_rx_data  = 8'h00;
    #12;
    chk("rst_data", bus.out_ram_data, 8'h00);
    chk("rst_txv", bus.out_tx_valid, 1'b0);
    chk("rst_rxr", bus.out_rx_ready, 1'b1);
    chk("rst_halt", bus.out_halt, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    // memory write, read-after-write, alias
    req(1'b1, 1'b1, 32'h10, 8'hA5); step;
    req(1'b1, 1'b0, 32'h10, 8'h00); step;
    chk("raw", bus.out_ram_data, 8'hA5);
    req(1'b1, 1'b1, 32'h20, 8'h11); step;
    req(1'b1, 1'b0, 32'h20010, 8'h00); step;
    chk("alias", bus.out_ram_data, 8'hA5);

    // TX push and drain
    req(1'b1, 1'b1, 32'h30000, 8'h41); step;
    req(1'b1, 1'b1, 32'h30000, 8'h42); step;
    req(1'b1, 1'b0, 32'h10, 8'h00);
    chk("tx_v", bus.out_tx_valid, 1'b1);
    chk("tx_d0", bus.out_tx_data, 8'h41);
    bus.in_tx_ready = 1'b1; step;
    chk("tx_d1", bus.out_tx_data, 8'h42);
    chk("tx_v1", bus.out_tx_valid, 1'b1);
    step;
    chk("tx_empty", bus.out_tx_valid, 1'b0);
    bus.in_tx_ready = 1'b0;

    // overflow: 9 pushes into depth 8
    for (int i = 1; i <= 9; i++) begin
      req(1'b1, 1'b1, 32'h30000, 8'(i)); step;
    end
    req(1'b1, 1'b0, 32'h30004, 8'h00); step;
    chk("ovf_stat", bus.out_ram_data, 8'h05);
    chk("ovf_head", bus.out_tx_data, 8'h01);
    req(1'b1, 1'b0, 32'h10, 8'h00);
    bus.in_tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) step;
    chk("ovf_last", bus.out_tx_data, 8'h08);
    chk("ovf_lastv", bus.out_tx_valid, 1'b1);
    step;
    chk("ovf_drain", bus.out_tx_valid, 1'b0);
    bus.in_tx_ready = 1'b0;

    // RX single byte
    bus.in_rx_valid = 1'b1;
    bus.in_rx_data  = 8'h7E; step;
    bus.in_rx_valid = 1'b0;
    req(1'b1, 1'b0, 32'h30000, 8'h00); step;
    chk("rx_byte", bus.out_ram_data, 8'h7E);
    step;
    chk("rx_empty", bus.out_ram_data, 8'h00);
    req(1'b1, 1'b0, 32'h30004, 8'h00); step;
    chk("rx_stat", bus.out_ram_data, 8'h04);
    req(1'b1, 1'b0, 32'h30008, 8'h00); step;
    chk("io_other", bus.out_ram_data, 8'h00);

    // RX fill to full
    req(1'b1, 1'b0, 32'h10, 8'h00);
    bus.in_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_rx_data = 8'hB0 + 8'(i); step;
    end
    chk("rx_full", bus.out_rx_ready, 1'b0);
    bus.in_rx_valid = 1'b0;
    req(1'b1, 1'b0, 32'h30000, 8'h00); step;
    chk("rx_head", bus.out_ram_data, 8'hB0);
    chk("rx_rdy", bus.out_rx_ready, 1'b1);

    // halt, status, rdy freeze
    req(1'b1, 1'b1, 32'h30004, 8'h99); step;
    chk("halt", bus.out_halt, 1'b1);
    req(1'b1, 1'b0, 32'h30004, 8'h00); step;
    chk("stat2", bus.out_ram_data, 8'h06);
    req(1'b0, 1'b1, 32'h20, 8'h33); step;
    req(1'b0, 1'b0, 32'h10, 8'h00); step;
    chk("hold", bus.out_ram_data, 8'h06);
    req(1'b1, 1'b0, 32'h20, 8'h00); step;
    chk("frozen_wr", bus.out_ram_data, 8'h11);

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 1'b1, 32'h30000, 8'hC0 + 8'(i)); step;
    end
    req(1'b1, 1'b0, 32'h10, 8'h00); step;
    chk("pre_rst", bus.out_ram_data, 8'hA5);
    chk("pre_rst_v", bus.out_tx_valid, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("arst_txv", bus.out_tx_valid, 1'b0);
    chk("arst_data", bus.out_ram_data, 8'h00);
    chk("arst_halt", bus.out_halt, 1'b0);
    chk("arst_rxr", bus.out_rx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    req(1'b1, 1'b0, 32'h10, 8'h00); step;
    chk("mem_kept", bus.out_ram_data, 8'hA5);
    req(1'b1, 1'b0, 32'h30004, 8'h00); step;
    chk("stat_rst", bus.out_ram_data, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
